// File: rtl/serv_bus_pkg.sv
// Shared types and constants for the SERV ibus/dbus to Wishbone arbiter.
package serv_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic int sel_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/serv_bus_arbiter_if.sv
// Bundle of the core-side ibus/dbus ports and the merged Wishbone master port.
interface serv_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import serv_bus_pkg::*;

    localparam int SEL_W = sel_width(DATA_WIDTH);

    logic [ADDR_WIDTH-1:0] ibus_adr_i;
    logic                  ibus_cyc_i;
    logic [DATA_WIDTH-1:0] ibus_rdt_o;
    logic                  ibus_ack_o;

    logic [ADDR_WIDTH-1:0] dbus_adr_i;
    logic [DATA_WIDTH-1:0] dbus_dat_i;
    logic [SEL_W-1:0]      dbus_sel_i;
    logic                  dbus_we_i;
    logic                  dbus_cyc_i;
    logic [DATA_WIDTH-1:0] dbus_rdt_o;
    logic                  dbus_ack_o;

    logic                  core_cyc_o;
    logic                  core_stb_o;
    logic                  core_we_o;
    logic [ADDR_WIDTH-1:0] core_addr_o;
    logic [DATA_WIDTH-1:0] core_data_o;
    logic [SEL_W-1:0]      core_sel_o;
    logic [DATA_WIDTH-1:0] core_data_i;
    logic                  core_ack_i;

    // Arbiter side
    modport slave (
        input  ibus_adr_i, ibus_cyc_i,
        output ibus_rdt_o, ibus_ack_o,
        input  dbus_adr_i, dbus_dat_i, dbus_sel_i, dbus_we_i, dbus_cyc_i,
        output dbus_rdt_o, dbus_ack_o,
        output core_cyc_o, core_stb_o, core_we_o, core_addr_o, core_data_o, core_sel_o,
        input  core_data_i, core_ack_i
    );

    // Core / memory-controller side
    modport master (
        output ibus_adr_i, ibus_cyc_i,
        input  ibus_rdt_o, ibus_ack_o,
        output dbus_adr_i, dbus_dat_i, dbus_sel_i, dbus_we_i, dbus_cyc_i,
        input  dbus_rdt_o, dbus_ack_o,
        input  core_cyc_o, core_stb_o, core_we_o, core_addr_o, core_data_o, core_sel_o,
        output core_data_i, core_ack_i
    );

endinterface

// File: rtl/serv_bus_arbiter.sv
// Merges SERV ibus and dbus onto one Wishbone-classic master port with
// dbus priority, fully registered outputs and a bus-hang timeout.
module serv_bus_arbiter
    import serv_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    serv_bus_arbiter_if.slave  bus,
    output logic               timeout_o,
    output logic               busy_o
);

    localparam int SEL_W = sel_width(DATA_WIDTH);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e            state_q,     state_d;
    arb_owner_e            owner_q,     owner_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  cyc_q,       cyc_d;
    logic                  we_q,        we_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic [SEL_W-1:0]      sel_q,       sel_d;
    logic [DATA_WIDTH-1:0] ibus_rdt_q,  ibus_rdt_d;
    logic [DATA_WIDTH-1:0] dbus_rdt_q,  dbus_rdt_d;
    logic                  ibus_ack_q,  ibus_ack_d;
    logic                  dbus_ack_q,  dbus_ack_d;
    logic                  timeout_q,   timeout_d;
    logic                  busy_q,      busy_d;
    logic                  timeout_hit_s;
    logic [DATA_WIDTH-1:0] resp_data_s;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        sel_d      = sel_q;
        ibus_rdt_d = ibus_rdt_q;
        dbus_rdt_d = dbus_rdt_q;
        ibus_ack_d = 1'b0;
        dbus_ack_d = 1'b0;
        timeout_d  = 1'b0;

        timeout_hit_s = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
        resp_data_s   = bus.core_ack_i ? bus.core_data_i : TIMEOUT_DATA;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.dbus_cyc_i) begin
                    state_d = DBUS;
                    owner_d = OWN_D;
                    cyc_d   = 1'b1;
                    we_d    = bus.dbus_we_i;
                    addr_d  = bus.dbus_adr_i;
                    data_d  = bus.dbus_dat_i;
                    sel_d   = bus.dbus_sel_i;
                end else if (bus.ibus_cyc_i) begin
                    state_d = IBUS;
                    owner_d = OWN_I;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = bus.ibus_adr_i;
                    data_d  = '0;
                    sel_d   = {SEL_W{1'b1}};
                end else begin
                    cyc_d = 1'b0;
                end
            end
            IBUS, DBUS: begin
                // A real ack takes precedence over a simultaneous timeout.
                if (bus.core_ack_i || timeout_hit_s) begin
                    state_d   = RESP;
                    cyc_d     = 1'b0;
                    cnt_d     = '0;
                    timeout_d = ~bus.core_ack_i;
                    if (owner_q == OWN_D) begin
                        dbus_rdt_d = resp_data_s;
                        dbus_ack_d = 1'b1;
                    end else begin
                        ibus_rdt_d = resp_data_s;
                        ibus_ack_d = 1'b1;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            cnt_q      <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            sel_q      <= '0;
            ibus_rdt_q <= '0;
            dbus_rdt_q <= '0;
            ibus_ack_q <= 1'b0;
            dbus_ack_q <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            ibus_rdt_q <= ibus_rdt_d;
            dbus_rdt_q <= dbus_rdt_d;
            ibus_ack_q <= ibus_ack_d;
            dbus_ack_q <= dbus_ack_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.core_cyc_o  = cyc_q;
    assign bus.core_stb_o  = cyc_q;
    assign bus.core_we_o   = we_q;
    assign bus.core_addr_o = addr_q;
    assign bus.core_data_o = data_q;
    assign bus.core_sel_o  = sel_q;
    assign bus.ibus_rdt_o  = ibus_rdt_q;
    assign bus.ibus_ack_o  = ibus_ack_q;
    assign bus.dbus_rdt_o  = dbus_rdt_q;
    assign bus.dbus_ack_o  = dbus_ack_q;
    assign timeout_o       = timeout_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Directed bench for serv_bus_arbiter: read/write, priority, timeout, reset.
module tb_serv_bus_arbiter;

    logic clk;
    logic rst;
    logic timeout_o;
    logic busy_o;
    int   checks;
    int   failures;
    int   n;

    serv_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    serv_bus_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .timeout_o (timeout_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.ibus_adr_i  = 32'h0;
        bus.ibus_cyc_i  = 1'b0;
        bus.dbus_adr_i  = 32'h0;
        bus.dbus_dat_i  = 32'h0;
        bus.dbus_sel_i  = 4'h0;
        bus.dbus_we_i   = 1'b0;
        bus.dbus_cyc_i  = 1'b0;
        bus.core_data_i = 32'h0;
        bus.core_ack_i  = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_cyc",  {31'd0, bus.core_cyc_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_irdt", bus.ibus_rdt_o, 32'h0);
        chk("rst_drdt", bus.dbus_rdt_o, 32'h0);
        chk("rst_acks", {29'd0, bus.ibus_ack_o, bus.dbus_ack_o, timeout_o}, 32'd0);
        rst = 1'b0;
        tick();

        // ibus read of 0x100, ack three cycles after cyc
        bus.ibus_adr_i = 32'h0000_0100;
        bus.ibus_cyc_i = 1'b1;
        tick();
        chk("i1_cyc",  {30'd0, bus.core_cyc_o, bus.core_stb_o}, 32'd3);
        chk("i1_we",   {31'd0, bus.core_we_o}, 32'd0);
        chk("i1_sel",  {28'd0, bus.core_sel_o}, 32'hF);
        chk("i1_addr", bus.core_addr_o, 32'h0000_0100);
        chk("i1_busy", {31'd0, busy_o}, 32'd1);
        tick();
        tick();
        chk("i1_cyc3", {31'd0, bus.core_cyc_o}, 32'd1);
        bus.core_ack_i  = 1'b1;
        bus.core_data_i = 32'h0000_0013;
        tick();
        chk("i1_iack", {31'd0, bus.ibus_ack_o}, 32'd1);
        chk("i1_irdt", bus.ibus_rdt_o, 32'h0000_0013);
        chk("i1_dack", {31'd0, bus.dbus_ack_o}, 32'd0);
        chk("i1_cyc_drop", {31'd0, bus.core_cyc_o}, 32'd0);
        chk("i1_busy_resp", {31'd0, busy_o}, 32'd1);
        bus.core_ack_i = 1'b0;
        bus.ibus_cyc_i = 1'b0;
        tick();
        chk("i1_iack_end", {31'd0, bus.ibus_ack_o}, 32'd0);
        chk("i1_busy_end", {31'd0, busy_o}, 32'd0);

        // dbus write, inputs wiggled mid-transfer to prove latching
        bus.dbus_adr_i = 32'h0000_2000;
        bus.dbus_dat_i = 32'hCAFE_BABE;
        bus.dbus_sel_i = 4'h3;
        bus.dbus_we_i  = 1'b1;
        bus.dbus_cyc_i = 1'b1;
        tick();
        chk("d1_we",   {31'd0, bus.core_we_o}, 32'd1);
        chk("d1_data", bus.core_data_o, 32'hCAFE_BABE);
        chk("d1_sel",  {28'd0, bus.core_sel_o}, 32'h3);
        chk("d1_addr", bus.core_addr_o, 32'h0000_2000);
        bus.dbus_dat_i = 32'h0;
        bus.dbus_adr_i = 32'hFFFF_FFFC;
        tick();
        chk("d1_data_hold", bus.core_data_o, 32'hCAFE_BABE);
        chk("d1_addr_hold", bus.core_addr_o, 32'h0000_2000);
        bus.core_ack_i  = 1'b1;
        bus.core_data_i = 32'h0;
        tick();
        chk("d1_dack", {31'd0, bus.dbus_ack_o}, 32'd1);
        chk("d1_iack", {31'd0, bus.ibus_ack_o}, 32'd0);
        bus.core_ack_i = 1'b0;
        bus.dbus_cyc_i = 1'b0;
        bus.dbus_we_i  = 1'b0;
        tick();
        chk("d1_dack_end", {31'd0, bus.dbus_ack_o}, 32'd0);
        tick();
        chk("d1_dack_once", {31'd0, bus.dbus_ack_o}, 32'd0);

        // Simultaneous requests: dbus then ibus
        bus.dbus_adr_i = 32'h0000_3000;
        bus.dbus_sel_i = 4'hF;
        bus.dbus_cyc_i = 1'b1;
        bus.ibus_adr_i = 32'h0000_0400;
        bus.ibus_cyc_i = 1'b1;
        tick();
        chk("pr_addr_d", bus.core_addr_o, 32'h0000_3000);
        bus.core_ack_i  = 1'b1;
        bus.core_data_i = 32'hAAAA_5555;
        tick();
        chk("pr_dack", {31'd0, bus.dbus_ack_o}, 32'd1);
        chk("pr_iack0", {31'd0, bus.ibus_ack_o}, 32'd0);
        chk("pr_drdt", bus.dbus_rdt_o, 32'hAAAA_5555);
        bus.core_ack_i = 1'b0;
        bus.dbus_cyc_i = 1'b0;
        tick();
        chk("pr_idle_cyc", {31'd0, bus.core_cyc_o}, 32'd0);
        tick();
        chk("pr_addr_i", bus.core_addr_o, 32'h0000_0400);
        chk("pr_cyc_i", {31'd0, bus.core_cyc_o}, 32'd1);
        bus.core_ack_i  = 1'b1;
        bus.core_data_i = 32'h0000_0055;
        tick();
        chk("pr_iack", {31'd0, bus.ibus_ack_o}, 32'd1);
        chk("pr_dack0", {31'd0, bus.dbus_ack_o}, 32'd0);
        chk("pr_irdt", bus.ibus_rdt_o, 32'h0000_0055);
        bus.core_ack_i = 1'b0;
        bus.ibus_cyc_i = 1'b0;
        tick();

        // Timeout: slave never acks
        bus.ibus_adr_i = 32'h0000_0500;
        bus.ibus_cyc_i = 1'b1;
        tick();
        n = 0;
        while (bus.core_cyc_o && n < 20) begin
            n++;
            tick();
        end
        chk("to_cycles", n, 32'd8);
        chk("to_iack", {31'd0, bus.ibus_ack_o}, 32'd1);
        chk("to_irdt", bus.ibus_rdt_o, 32'hDEAD_BEEF);
        chk("to_pulse", {31'd0, timeout_o}, 32'd1);
        bus.ibus_cyc_i = 1'b0;
        tick();
        chk("to_pulse_end", {31'd0, timeout_o}, 32'd0);
        bus.core_ack_i  = 1'b1;
        bus.core_data_i = 32'h0000_0099;
        tick();
        tick();
        chk("sp_iack", {30'd0, bus.ibus_ack_o, bus.dbus_ack_o}, 32'd0);
        chk("sp_busy", {31'd0, busy_o}, 32'd0);
        chk("sp_irdt", bus.ibus_rdt_o, 32'hDEAD_BEEF);
        bus.core_ack_i = 1'b0;
        tick();

        // Ack on the last cycle before timeout wins
        bus.ibus_adr_i = 32'h0000_0600;
        bus.ibus_cyc_i = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("ta_cyc8", {31'd0, bus.core_cyc_o}, 32'd1);
        bus.core_ack_i  = 1'b1;
        bus.core_data_i = 32'h1234_5678;
        tick();
        chk("ta_iack", {31'd0, bus.ibus_ack_o}, 32'd1);
        chk("ta_irdt", bus.ibus_rdt_o, 32'h1234_5678);
        chk("ta_nopulse", {31'd0, timeout_o}, 32'd0);
        bus.core_ack_i = 1'b0;
        bus.ibus_cyc_i = 1'b0;
        tick();

        // Reset in the middle of a dbus transfer
        bus.dbus_adr_i = 32'h0000_0700;
        bus.dbus_dat_i = 32'h1111_2222;
        bus.dbus_we_i  = 1'b1;
        bus.dbus_cyc_i = 1'b1;
        tick();
        tick();
        chk("rm_cyc_pre", {31'd0, bus.core_cyc_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rm_cyc",  {30'd0, bus.core_cyc_o, bus.core_stb_o}, 32'd0);
        chk("rm_we",   {31'd0, bus.core_we_o}, 32'd0);
        chk("rm_addr", bus.core_addr_o, 32'h0);
        chk("rm_data", bus.core_data_o, 32'h0);
        chk("rm_busy", {31'd0, busy_o}, 32'd0);
        chk("rm_irdt", bus.ibus_rdt_o, 32'h0);
        chk("rm_dack", {31'd0, bus.dbus_ack_o}, 32'd0);
        bus.dbus_cyc_i = 1'b0;
        bus.dbus_we_i  = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("rm_dack_after", {31'd0, bus.dbus_ack_o}, 32'd0);
        bus.ibus_adr_i = 32'h0000_0000;
        bus.ibus_cyc_i = 1'b1;
        tick();
        chk("rr_cyc",  {31'd0, bus.core_cyc_o}, 32'd1);
        chk("rr_addr", bus.core_addr_o, 32'h0);
        bus.core_ack_i  = 1'b1;
        bus.core_data_i = 32'h0000_0297;
        tick();
        chk("rr_iack", {31'd0, bus.ibus_ack_o}, 32'd1);
        chk("rr_irdt", bus.ibus_rdt_o, 32'h0000_0297);
        bus.core_ack_i = 1'b0;
        bus.ibus_cyc_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serv_bus_arbiter.md
Name: serv_bus_arbiter

Overview:
- Merges the SERV core's separate instruction bus (ibus) and data bus (dbus) onto the single Wishbone-classic master port (core_cyc/stb/we/addr/data/ack).
- That port is consumed by the Controller, or by the simulation bench.
- Sits directly downstream of serv_top, between the core and the memory controller.
- Adds a registered handshake, fixed dbus-over-ibus priority and a bus-hang timeout.

Parameters:
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus data width (SEL width = DATA_WIDTH/8)
- TIMEOUT_CYCLES, 1024, cycles in IBUS/DBUS without ack before abort; 0 disables timeout
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on an aborted transfer

Ports:
- clk  in  1  core clock (clk_core)
- rst  in  1  asynchronous, active-high reset
- ibus_adr_i  in  ADDR_WIDTH  instruction fetch address
- ibus_cyc_i  in  1  instruction fetch request
- ibus_rdt_o  out  DATA_WIDTH  fetched instruction
- ibus_ack_o  out  1  fetch complete, single-cycle pulse
- dbus_adr_i  in  ADDR_WIDTH  data address
- dbus_dat_i  in  DATA_WIDTH  write data
- dbus_sel_i  in  DATA_WIDTH/8  byte enables
- dbus_we_i  in  1  1 = write
- dbus_cyc_i  in  1  data request
- dbus_rdt_o  out  DATA_WIDTH  load data
- dbus_ack_o  out  1  data complete, single-cycle pulse
- core_cyc_o  out  1  Wishbone cycle
- core_stb_o  out  1  Wishbone strobe
- core_we_o  out  1  Wishbone write enable
- core_addr_o  out  ADDR_WIDTH  Wishbone address
- core_data_o  out  DATA_WIDTH  Wishbone write data
- core_sel_o  out  DATA_WIDTH/8  Wishbone byte select
- core_data_i  in  DATA_WIDTH  Wishbone read data
- core_ack_i  in  1  Wishbone acknowledge
- timeout_o  out  1  one-cycle pulse on an aborted transfer
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: all outputs 0, including rdt registers; state IDLE; timeout counter 0. Assertion of rst clears outputs immediately, without waiting for a clock edge.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states: IDLE, IBUS, DBUS, RESP.
- IDLE:
  - dbus_cyc_i=1 -> latch dbus_adr/dat/sel/we; go to DBUS.
  - Else ibus_cyc_i=1 -> latch ibus_adr, we=0, sel=all-ones, data=0; go to IBUS.
  - dbus wins when both requests are asserted together; the ibus request stays pending and is granted on a later IDLE pass.
- IBUS/DBUS:
  - core_cyc_o = core_stb_o = 1 and the latched fields are driven.
  - Address, data, sel and we stay stable for the whole transfer.
  - The timeout counter increments each cycle.
- core_ack_i=1 sampled in IBUS/DBUS:
  - Capture core_data_i into the owning rdt register; for dbus writes rdt captures core_data_i as well, value is don't-care.
  - Clear cyc/stb; go to RESP; counter cleared.
- Timeout:
  - Triggers when counter == TIMEOUT_CYCLES-1 and core_ack_i=0.
  - Action: clear cyc/stb, load TIMEOUT_DATA into the owner's rdt, pulse timeout_o in RESP, go to RESP.
  - If ack and timeout coincide on the same cycle, ack wins: real data is captured and timeout_o stays 0.
- RESP: the owner's ack_o is high for exactly this one cycle; next state is IDLE. The non-owner's ack_o stays 0.
- Master rule (SERV/Wishbone): the master drops cyc in the cycle after it samples ack. IDLE therefore never re-grants a completed request.
- rdt registers change only at capture and hold their value between transfers.
- Latency:
  - Request sampled at edge k -> core_cyc_o high from cycle k+1.
  - core_ack_i sampled at edge m -> ibus/dbus_ack_o high in cycle m+1.
  - Minimum round-trip with a zero-wait slave: 3 cycles from request to ack_o.
- core_ack_i while IDLE or RESP (late or spurious ack): ignored; no state change, no data capture.
- Reset mid-transfer: cyc/stb drop asynchronously; no ack_o is produced for the killed transfer.
- Counter width: $clog2(TIMEOUT_CYCLES+1); no wrap, since it is cleared on leaving IBUS/DBUS.

Decomposition:
- Package serv_bus_pkg:
  - state enum (IDLE, IBUS, DBUS, RESP)
  - owner enum (OWN_I, OWN_D)
  - localparams for the default TIMEOUT_DATA and the SEL width function
- Single module; no sub-module. The timeout counter is simple enough to stay inline.

Test Plan:
- ibus read of 0x0000_0100, slave acks 3 cycles after cyc with 0x0000_0013 -> core_we_o=0, core_sel_o=4'hF, core_addr_o=0x100; ibus_ack_o one-cycle pulse with ibus_rdt_o=0x13; dbus_ack_o stays 0; busy_o falls after RESP.
- dbus write 0x0000_2000, dat 0xCAFE_BABE, sel 4'h3 -> core_we_o=1, core_data_o=0xCAFEBABE, core_sel_o=4'h3, all stable until ack; exactly one dbus_ack_o pulse.
- ibus_cyc_i and dbus_cyc_i rise on the same edge -> dbus transfer first, then ibus transfer; each ack_o pulses once, in order D then I.
- TIMEOUT_CYCLES=8, ibus read, slave never acks -> core_cyc_o drops after 8 cycles; ibus_ack_o with rdt=0xDEADBEEF; timeout_o pulses once; a later spurious core_ack_i is ignored with no extra ack_o.
- TIMEOUT_CYCLES=8, slave acks on the 8th cycle with 0x1234_5678 -> rdt=0x12345678 and timeout_o=0.
- rst asserted mid-DBUS -> all outputs 0 before the next clock edge, no dbus_ack_o; after release, a normal ibus read of 0x0 completes correctly.
